// File: rtl/pacman_motion.sv
// pacman_motion: per-frame Pac-Man turn/move controller that probes walls through a query port
module pacman_motion #(
   parameter int START_X = 202,
   parameter int START_Y = 324,
   parameter int SIZE    = 13,
   parameter int STEP    = 1,
   parameter int X_MIN   = 13,
   parameter int X_MAX   = 391,
   parameter int Y_MIN   = 13,
   parameter int Y_MAX   = 434
) (
   input  logic       Clk,
   input  logic       Reset,
   input  logic       frame_clk,
   input  logic [7:0] keycode,
   output logic       q_valid,
   input  logic       q_ready,
   output logic [9:0] q_x,
   output logic [9:0] q_y,
   input  logic       r_valid,
   input  logic       r_wall,
   output logic [9:0] BallX,
   output logic [9:0] BallY,
   output logic [9:0] Ball_size,
   output logic [3:0] l_dirX,
   output logic [3:0] l_dirY,
   output logic       busy
);
   typedef enum logic [2:0] {IDLE, TURN_REQ, TURN_WAIT, FWD_REQ, FWD_WAIT, UPDATE} state_t;
   typedef enum logic [2:0] {D_NONE, D_LEFT, D_RIGHT, D_UP, D_DOWN} dir_t;
   localparam logic signed [10:0] OFF = 11'(SIZE + STEP);
   localparam logic signed [10:0] STP = 11'(STEP);
   localparam logic signed [10:0] XMN = 11'(X_MIN);
   localparam logic signed [10:0] XMX = 11'(X_MAX);
   localparam logic signed [10:0] YMN = 11'(Y_MIN);
   localparam logic signed [10:0] YMX = 11'(Y_MAX);
   state_t state_q, state_d;
   dir_t dir_q, dir_d, pend_q, pend_d, turn_q, turn_d, key_dir, pend_now, probe_dir;
   logic [2:0] sync_q, sync_d;
   logic tick_q, tick_d, wall_q, wall_d, oob;
   logic [9:0] x_q, x_d, y_q, y_d;
   logic signed [10:0] xs, ys, px, py, nx, ny;
   always_comb begin
      key_dir = keycode == 8'h1A ? D_UP : keycode == 8'h04 ? D_LEFT :
                keycode == 8'h16 ? D_DOWN : keycode == 8'h07 ? D_RIGHT : D_NONE;
      pend_now = key_dir != D_NONE ? key_dir : pend_q;
      probe_dir = state_q == TURN_REQ ? turn_q : dir_q;
      xs = $signed({1'b0, x_q});
      ys = $signed({1'b0, y_q});
      px = xs + (probe_dir == D_RIGHT ? OFF : probe_dir == D_LEFT ? -OFF : 11'sd0);
      py = ys + (probe_dir == D_DOWN ? OFF : probe_dir == D_UP ? -OFF : 11'sd0);
      // probes off the visible maze never reach the lookup and count as open
      oob = px[10] | py[10] | (px > 11'sd404) | (py > 11'sd447);
      nx = dir_q == D_LEFT ? ((xs - STP) < XMN ? XMX : xs - STP) :
           dir_q == D_RIGHT ? ((xs + STP) > XMX ? XMN : xs + STP) : xs;
      ny = dir_q == D_UP ? ((ys - STP) < YMN ? YMN : ys - STP) :
           dir_q == D_DOWN ? ((ys + STP) > YMX ? YMX : ys + STP) : ys;
      sync_d = {sync_q[1:0], frame_clk};
      tick_d = sync_q[1] & ~sync_q[2];
      state_d = state_q;
      dir_d = dir_q;
      pend_d = pend_now;
      turn_d = turn_q;
      wall_d = wall_q;
      x_d = x_q;
      y_d = y_q;
      case (state_q)
         IDLE:
            if (tick_q) begin
               if (pend_now != D_NONE && pend_now != dir_q) begin
                  state_d = TURN_REQ;
                  turn_d = pend_now;
               end else if (dir_q != D_NONE) state_d = FWD_REQ;
            end
         TURN_REQ:
            if (oob) begin
               dir_d = turn_q;
               pend_d = D_NONE;
               state_d = FWD_REQ;
            end else if (q_ready) state_d = TURN_WAIT;
         TURN_WAIT:
            if (r_valid) begin
               if (!r_wall) begin
                  dir_d = turn_q;
                  pend_d = D_NONE;
                  state_d = FWD_REQ;
               end else state_d = dir_q != D_NONE ? FWD_REQ : IDLE;
            end
         FWD_REQ:
            if (oob) begin
               wall_d = 1'b0;
               state_d = UPDATE;
            end else if (q_ready) state_d = FWD_WAIT;
         FWD_WAIT:
            if (r_valid) begin
               wall_d = r_wall;
               state_d = UPDATE;
            end
         UPDATE: begin
            if (!wall_q) begin
               x_d = nx[9:0];
               y_d = ny[9:0];
            end
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q <= IDLE;
         dir_q <= D_NONE;
         pend_q <= D_NONE;
         turn_q <= D_NONE;
         sync_q <= '0;
         tick_q <= 1'b0;
         wall_q <= 1'b0;
         x_q <= 10'(START_X);
         y_q <= 10'(START_Y);
      end else begin
         state_q <= state_d;
         dir_q <= dir_d;
         pend_q <= pend_d;
         turn_q <= turn_d;
         sync_q <= sync_d;
         tick_q <= tick_d;
         wall_q <= wall_d;
         x_q <= x_d;
         y_q <= y_d;
      end
   end
   assign q_valid = (state_q == TURN_REQ || state_q == FWD_REQ) && !oob;
   assign q_x = px[9:0];
   assign q_y = py[9:0];
   assign BallX = x_q;
   assign BallY = y_q;
   assign Ball_size = 10'(SIZE);
   assign l_dirX = dir_q == D_LEFT ? 4'd1 : dir_q == D_RIGHT ? 4'd3 : 4'd0;
   assign l_dirY = dir_q == D_UP ? 4'd1 : dir_q == D_DOWN ? 4'd3 : 4'd0;
   assign busy = state_q != IDLE;
endmodule

// File: tb/tb_pacman_motion.sv
// tb_pacman_motion: table-driven frame vectors plus wrap, clamp, reset and busy-tick sequences
module tb_pacman_motion;
   logic Clk, Reset, frame_clk, q_valid, q_ready, r_valid, r_wall, busy;
   logic r_valid_a, r_wall_a, r_valid_m, r_wall_m, wall_all, wall_up;
   logic [7:0] keycode;
   logic [9:0] q_x, q_y, BallX, BallY, Ball_size, cap_y, cap_by;
   logic [3:0] l_dirX, l_dirY;
   int tests, fails, lat, hs_cnt, qv_cnt, qv0, h0;
   typedef struct {
      logic [7:0] key;
      logic       wall_all;
      logic       wall_up;
      int         x, y, dx, dy;
   } vec_t;
   vec_t tbl[16];
   assign r_valid = r_valid_a | r_valid_m;
   assign r_wall = r_wall_a | r_wall_m;
   pacman_motion dut (
      .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .keycode(keycode),
      .q_valid(q_valid), .q_ready(q_ready), .q_x(q_x), .q_y(q_y),
      .r_valid(r_valid), .r_wall(r_wall), .BallX(BallX), .BallY(BallY),
      .Ball_size(Ball_size), .l_dirX(l_dirX), .l_dirY(l_dirY), .busy(busy)
   );
   initial Clk = 1'b0;
   always #5 Clk = ~Clk;
   // lookup model: answers each accepted query after lat cycles
   initial begin
      hs_cnt = 0;
      r_valid_a = 1'b0;
      r_wall_a = 1'b0;
      forever begin
         @(negedge Clk);
         r_valid_a = 1'b0;
         r_wall_a = 1'b0;
         if (q_valid && q_ready) begin
            cap_y = q_y;
            cap_by = BallY;
            hs_cnt++;
            repeat (lat) @(negedge Clk);
            r_wall_a = wall_all || (wall_up && cap_y < cap_by);
            r_valid_a = 1'b1;
         end
      end
   end
   initial begin
      qv_cnt = 0;
      forever begin
         @(negedge Clk);
         if (q_valid) qv_cnt++;
      end
   end
   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1);
   end
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d required %0d", name, act, exp);
      end
   endtask
   task automatic press(input logic [7:0] k);
      keycode = k;
      @(negedge Clk);
      keycode = 8'h00;
   endtask
   task automatic frame();
      int n;
      frame_clk = 1'b1;
      repeat (6) @(negedge Clk);
      frame_clk = 1'b0;
      n = 0;
      while (busy && n < 300) begin
         @(negedge Clk);
         n++;
      end
      chk("frame_done", busy, 0);
      repeat (3) @(negedge Clk);
   endtask
   initial begin
      int n;
      tests = 0;
      fails = 0;
      lat = 1;
      wall_all = 1'b0;
      wall_up = 1'b0;
      Reset = 1'b1;
      frame_clk = 1'b0;
      keycode = 8'h00;
      q_ready = 1'b1;
      r_valid_m = 1'b0;
      r_wall_m = 1'b0;
      tbl[0]  = '{8'h00, 1'b0, 1'b0, 202, 324, 0, 0};
      tbl[1]  = '{8'h00, 1'b0, 1'b0, 202, 324, 0, 0};
      tbl[2]  = '{8'h00, 1'b0, 1'b0, 202, 324, 0, 0};
      tbl[3]  = '{8'h07, 1'b0, 1'b0, 203, 324, 3, 0};
      tbl[4]  = '{8'h00, 1'b0, 1'b0, 204, 324, 3, 0};
      tbl[5]  = '{8'h00, 1'b0, 1'b0, 205, 324, 3, 0};
      tbl[6]  = '{8'h00, 1'b0, 1'b0, 206, 324, 3, 0};
      tbl[7]  = '{8'h00, 1'b0, 1'b0, 207, 324, 3, 0};
      tbl[8]  = '{8'h1A, 1'b0, 1'b1, 208, 324, 3, 0};
      tbl[9]  = '{8'h00, 1'b0, 1'b0, 208, 323, 0, 1};
      tbl[10] = '{8'h00, 1'b0, 1'b0, 208, 322, 0, 1};
      tbl[11] = '{8'h55, 1'b0, 1'b0, 208, 321, 0, 1};
      tbl[12] = '{8'h00, 1'b1, 1'b0, 208, 321, 0, 1};
      tbl[13] = '{8'h16, 1'b1, 1'b0, 208, 321, 0, 1};
      tbl[14] = '{8'h00, 1'b0, 1'b0, 208, 322, 0, 3};
      tbl[15] = '{8'h04, 1'b0, 1'b0, 207, 322, 1, 0};
      repeat (3) @(negedge Clk);
      Reset = 1'b0;
      @(negedge Clk);
      chk("rst_x", BallX, 202);
      chk("rst_y", BallY, 324);
      chk("rst_dx", l_dirX, 0);
      chk("rst_dy", l_dirY, 0);
      chk("rst_qv", q_valid, 0);
      chk("rst_busy", busy, 0);
      chk("size", Ball_size, 13);
      qv0 = qv_cnt;
      for (int i = 0; i < 16; i++) begin
         wall_all = tbl[i].wall_all;
         wall_up = tbl[i].wall_up;
         if (tbl[i].key != 8'h00) press(tbl[i].key);
         frame();
         chk($sformatf("row%0d_x", i), BallX, tbl[i].x);
         chk($sformatf("row%0d_y", i), BallY, tbl[i].y);
         chk($sformatf("row%0d_dx", i), l_dirX, tbl[i].dx);
         chk($sformatf("row%0d_dy", i), l_dirY, tbl[i].dy);
         if (i == 2) chk("idle_no_query", qv_cnt - qv0, 0);
      end
      wall_all = 1'b0;
      wall_up = 1'b0;
      press(8'h1A);
      frame();
      chk("turn_up_y", BallY, 321);
      n = 0;
      while (BallY != 10'd13 && n < 400) begin
         frame();
         n++;
      end
      chk("reach_ymin", BallY, 13);
      frame();
      chk("y_clamp", BallY, 13);
      chk("y_clamp_dy", l_dirY, 1);
      press(8'h04);
      frame();
      chk("turn_left_x", BallX, 206);
      n = 0;
      while (BallX != 10'd13 && n < 300) begin
         frame();
         n++;
      end
      chk("reach_xmin", BallX, 13);
      frame();
      chk("wrap_left", BallX, 391);
      chk("wrap_left_dx", l_dirX, 1);
      press(8'h07);
      frame();
      chk("wrap_right", BallX, 13);
      chk("wrap_right_dx", l_dirX, 3);
      chk("wrap_right_dy", l_dirY, 0);
      q_ready = 1'b0;
      frame_clk = 1'b1;
      n = 0;
      while (!q_valid && n < 20) begin
         @(negedge Clk);
         n++;
      end
      chk("stall_qv", q_valid, 1);
      for (int i = 0; i < 5; i++) begin
         @(negedge Clk);
         chk("stall_qv_hold", q_valid, 1);
         chk("stall_qx", q_x, 27);
         chk("stall_qy", q_y, 13);
      end
      Reset = 1'b1;
      @(negedge Clk);
      Reset = 1'b0;
      frame_clk = 1'b0;
      chk("mid_rst_qv", q_valid, 0);
      chk("mid_rst_x", BallX, 202);
      chk("mid_rst_y", BallY, 324);
      chk("mid_rst_dx", l_dirX, 0);
      chk("mid_rst_dy", l_dirY, 0);
      chk("mid_rst_busy", busy, 0);
      h0 = hs_cnt;
      q_ready = 1'b1;
      r_valid_m = 1'b1;
      @(negedge Clk);
      r_valid_m = 1'b0;
      repeat (3) @(negedge Clk);
      chk("late_rv_busy", busy, 0);
      chk("late_rv_x", BallX, 202);
      chk("late_rv_dx", l_dirX, 0);
      chk("late_rv_query", hs_cnt - h0, 0);
      press(8'h07);
      frame();
      chk("restart_x", BallX, 203);
      lat = 40;
      h0 = hs_cnt;
      frame_clk = 1'b1;
      repeat (6) @(negedge Clk);
      frame_clk = 1'b0;
      repeat (4) @(negedge Clk);
      chk("busy_in_wait", busy, 1);
      frame_clk = 1'b1;
      repeat (6) @(negedge Clk);
      frame_clk = 1'b0;
      n = 0;
      while (busy && n < 300) begin
         @(negedge Clk);
         n++;
      end
      chk("busy_done", busy, 0);
      repeat (20) @(negedge Clk);
      chk("dropped_tick_query", hs_cnt - h0, 1);
      chk("dropped_tick_x", BallX, 204);
      lat = 1;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
